// File: rtl/inv_key_schedule.sv
// Iterative AES-128 round-key generator for the decryption datapath.
// The cipher key is expanded forward to round 10 in a single 128-bit working
// register. Round keys are then walked backward, one per accepted
// valid/ready handshake, so that no 11-entry key store is needed.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    SERVE  = 2'd2
  } state_t;

  // Forward AES S-box, byte 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant for rounds 1..10; round 0 never reaches the S-box path.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           done_q, done_d;

  // Working-register words, w0 in the top 32 bits.
  logic [31:0]    w0, w1, w2, w3;
  // Backward-step partial results.
  logic [31:0]    p1, p2, p3;
  logic [31:0]    sbox_in, rot_word, sub_word, t_word;
  logic [10:0]    sbox_idx [4];
  logic [127:0]   fwd_key, inv_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign p1 = w0 ^ w1;
  assign p2 = w1 ^ w2;
  assign p3 = w2 ^ w3;

  // One shared S-box group: forward expansion feeds w3, the backward step
  // needs the recovered previous w3, which is c2^c3.
  assign sbox_in  = (state_q == SERVE) ? p3 : w3;
  assign rot_word = {sbox_in[23:0], sbox_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sbox_idx[gi] = 11'd2047 - {rot_word[8*gi +: 8], 3'b000};
      assign sub_word[8*gi +: 8] = SBOX[sbox_idx[gi] -: 8];
    end
  endgenerate

  assign t_word = sub_word ^ {rcon(cnt_q), 24'h000000};

  // Forward round: each new word chains off the one just produced.
  always_comb begin
    fwd_key[127:96] = w0 ^ t_word;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
  end

  assign inv_key = {w0 ^ t_word, p1, p2, p3};

  // State, working register, round counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load, expand forward to round 10, then step backward per transfer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d = fwd_key;
        if (cnt_q == 4'd10) begin
          state_d = SERVE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SERVE: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            key_d = inv_key;
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registers only; rk_ready never reaches rk_valid.
  always_comb begin
    busy     = (state_q != IDLE);
    rk_valid = (state_q == SERVE);
    rk_out   = (state_q == SERVE) ? key_q : '0;
    rk_round = (state_q == SERVE) ? cnt_q : '0;
    done     = done_q;
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule. Expected round keys come from a
// plain forward FIPS-197 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];

  inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] v8;
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      v8  = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(v8, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pulse start for one edge; called at a falling edge.
  task automatic kick(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Bounded wait for rk_valid; returns the number of falling edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!rk_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b round=%0d out=%h required all zero",
               busy, rk_valid, done, rk_round, rk_out);
    end
    rst = 1'b0;
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b valid=%b required 0 0", busy, rk_valid);
    end
    rk_ready = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fips();
    int n;
    build_model(FIPS_KEY);
    rk_ready = 1'b1;
    kick(FIPS_KEY);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fips_busy: busy=%b required 1", busy);
    end
    wait_valid(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL fips_latency: cycles=%0d required 10", n);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r] || done !== 1'b0) begin
        errors++;
        $display("FAIL fips_key: valid=%b round=%0d out=%h done=%b required 1 %0d %h 0",
                 rk_valid, rk_round, rk_out, done, r, exp_rk[r]);
      end
      if (r == 10 || r == 1 || r == 0) begin
        checks++;
        if (rk_out !== ((r == 10) ? FIPS_RK10 : (r == 1) ? FIPS_RK1 : FIPS_KEY)) begin
          errors++;
          $display("FAIL fips_vector_r%0d: out=%h", r, rk_out);
        end
      end
      $display("fips round %0d key %h", rk_round, rk_out);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 || rk_out !== '0) begin
      errors++;
      $display("FAIL fips_done: done=%b busy=%b valid=%b out=%h required 1 0 0 0",
               done, busy, rk_valid, rk_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL fips_done_width: done=%b required 0", done);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    int xfers;
    int exp_r;
    int cyc;
    logic         stalled;
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    build_model(FIPS_KEY);
    rk_ready = 1'b0;
    kick(FIPS_KEY);
    wait_valid(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL bp_latency: cycles=%0d required 10", n);
    end
    xfers = 0; exp_r = 10; cyc = 0; stalled = 1'b0;
    prev_out = '0; prev_round = '0;
    while (xfers < 11 && cyc < 400) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(exp_r) || rk_out !== exp_rk[exp_r]) begin
        errors++;
        $display("FAIL bp_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, exp_r, exp_rk[exp_r]);
      end
      if (stalled) begin
        checks++;
        if (rk_out !== prev_out || rk_round !== prev_round) begin
          errors++;
          $display("FAIL bp_hold: round=%0d out=%h required %0d %h",
                   rk_round, rk_out, prev_round, prev_out);
        end
      end
      prev_out   = rk_out;
      prev_round = rk_round;
      rk_ready   = ($urandom_range(0, 99) < 40);
      stalled    = !rk_ready;
      if (rk_ready) $display("bp transfer round %0d key %h", rk_round, rk_out);
      @(negedge clk);
      cyc++;
      if (rk_ready) begin
        xfers++;
        exp_r--;
      end
    end
    rk_ready = 1'b0;
    checks++;
    if (xfers != 11 || done !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: transfers=%0d done=%b valid=%b required 11 1 0",
               xfers, done, rk_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_back_to_back();
    int n;
    build_model('0);
    rk_ready = 1'b1;
    kick('0);
    wait_valid(n);
    checks++;
    if (n != 10 || rk_out !== ZERO_RK10) begin
      errors++;
      $display("FAIL zero_rk10: cycles=%0d out=%h required 10 %h", n, rk_out, ZERO_RK10);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL zero_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      if (r == 0) begin
        checks++;
        if (rk_out !== '0) begin
          errors++;
          $display("FAIL zero_rk0: out=%h required 0", rk_out);
        end
      end
      $display("zero round %0d key %h", rk_round, rk_out);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done=%b required 1", done);
    end
    // Restart in the same cycle done is high.
    build_model(FIPS_KEY);
    kick(FIPS_KEY);
    wait_valid(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_latency: cycles=%0d required 10", n);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL b2b_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      $display("b2b round %0d key %h", rk_round, rk_out);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b required 1", done);
    end
    rk_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int n;
    int done_cnt;
    logic [127:0] k;
    k = rand_key();
    build_model(k);
    rk_ready = 1'b1;
    kick(k);
    repeat (2) @(negedge clk);
    start  = 1'b1;
    key_in = rand_key();
    @(negedge clk);
    start  = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL busy_latency: cycles=%0d required 7", n);
    end
    done_cnt = 0;
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL busy_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      $display("busy-start round %0d key %h", rk_round, rk_out);
      done_cnt += int'(done);
      start  = (r == 5);
      key_in = rand_key();
      @(negedge clk);
    end
    repeat (6) begin
      done_cnt += int'(done);
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_done_count: dones=%0d busy=%b required 1 0", done_cnt, busy);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    logic [127:0] k;
    k = rand_key();
    build_model(k);
    rk_ready = 1'b1;
    kick(k);
    wait_valid(n);
    for (int r = 10; r >= 6; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL ar_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      @(negedge clk);
    end
    checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd5) begin
      errors++;
      $display("FAIL ar_pre: valid=%b round=%0d required 1 5", rk_valid, rk_round);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
      errors++;
      $display("FAIL ar_immediate: busy=%b valid=%b done=%b round=%0d out=%h required all zero",
               busy, rk_valid, done, rk_round, rk_out);
    end
    $display("async reset applied mid-serve");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k = rand_key();
    build_model(k);
    kick(k);
    wait_valid(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL ar_latency: cycles=%0d required 10", n);
    end
    for (int r = 10; r >= 0; r--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
        errors++;
        $display("FAIL ar_rerun_key: valid=%b round=%0d out=%h required 1 %0d %h",
                 rk_valid, rk_round, rk_out, r, exp_rk[r]);
      end
      $display("after-reset round %0d key %h", rk_round, rk_out);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ar_done: done=%b required 1", done);
    end
    rk_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_keys();
    int n;
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = rand_key();
      build_model(k);
      rk_ready = 1'b1;
      kick(k);
      wait_valid(n);
      for (int r = 10; r >= 0; r--) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_out !== exp_rk[r]) begin
          errors++;
          $display("FAIL rand_key: valid=%b round=%0d out=%h required 1 %0d %h",
                   rk_valid, rk_round, rk_out, r, exp_rk[r]);
        end
        @(negedge clk);
      end
      $display("random key %h served", k);
      rk_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips();
    test_backpressure();
    test_zero_back_to_back();
    test_start_while_busy();
    test_async_reset();
    test_random_keys();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
